window_energy_cutter: RTL

WINDOW_ENERGY_CUTTER -- requirements
Module: window_energy_cutter

---
 rtl/window_energy_cutter_if.sv | 28 ++
 rtl/window_energy_cutter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/window_energy_cutter_if.sv
// Bus bundle for window_energy_cutter: sample stream, threshold and
// energy/activity results.
interface window_energy_cutter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int WIN_LOG2   = 4
);
    localparam int ACC_WIDTH = DATA_WIDTH + WIN_LOG2;

    logic                  flush;
    logic                  sq_valid;
    logic [DATA_WIDTH-1:0] sq_data;
    logic [ACC_WIDTH-1:0]  threshold;
    logic                  energy_valid;
    logic [ACC_WIDTH-1:0]  energy;
    logic                  active;
    logic                  onset;
    logic                  offset;

    modport master (
        output flush, sq_valid, sq_data, threshold,
        input  energy_valid, energy, active, onset, offset
    );

    modport slave (
        input  flush, sq_valid, sq_data, threshold,
        output energy_valid, energy, active, onset, offset
    );
endinterface

// File: rtl/window_energy_cutter.sv
// Sliding-window energy detector: N-sample running sum compared against a
// threshold, with a hold-off before releasing the active level.
module window_energy_cutter #(
    parameter int DATA_WIDTH   = 32,
    parameter int WIN_LOG2     = 4,
    parameter int HOLD_SAMPLES = 8
) (
    input logic                    clk,
    input logic                    rst,
    window_energy_cutter_if.slave  bus
);
    localparam int ACC_WIDTH = DATA_WIDTH + WIN_LOG2;
    localparam int N         = 1 << WIN_LOG2;
    localparam int HW        = $clog2(HOLD_SAMPLES + 1);

    localparam logic [WIN_LOG2:0] FILL_MAX  = (WIN_LOG2+1)'(N);
    localparam logic [WIN_LOG2:0] FILL_LAST = (WIN_LOG2+1)'(N - 1);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_SAMPLES - 1);

    typedef enum logic [1:0] {FILL, BELOW, ABOVE, HOLD} state_e;

    logic [DATA_WIDTH-1:0] win_q [N];
    logic [DATA_WIDTH-1:0] win_d [N];
    logic [ACC_WIDTH-1:0]  sum_q, sum_d;
    logic [WIN_LOG2-1:0]   wp_q, wp_d;
    logic [WIN_LOG2:0]     fill_q, fill_d;
    logic                  ev_q, ev_d;
    logic [HW-1:0]         hold_q, hold_d;
    state_e                state_q, state_d;
    logic                  active_q, active_d;
    logic                  onset_q, onset_d;
    logic                  offset_q, offset_d;
    logic                  above;

    // Window datapath: replace oldest sample and adjust running sum.
    always_comb begin
        win_d  = win_q;
        sum_d  = sum_q;
        wp_d   = wp_q;
        fill_d = fill_q;
        ev_d   = 1'b0;
        if (bus.flush) begin
            for (int i = 0; i < N; i++) win_d[i] = '0;
            sum_d  = '0;
            wp_d   = '0;
            fill_d = '0;
        end else if (bus.sq_valid) begin
            win_d[wp_q] = bus.sq_data;
            sum_d = sum_q + ACC_WIDTH'(bus.sq_data)
                  - ACC_WIDTH'(win_q[wp_q]);
            wp_d  = wp_q + 1'b1;
            if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
            ev_d  = (fill_q >= FILL_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) win_q[i] <= '0;
            sum_q  <= '0;
            wp_q   <= '0;
            fill_q <= '0;
            ev_q   <= 1'b0;
        end else begin
            win_q  <= win_d;
            sum_q  <= sum_d;
            wp_q   <= wp_d;
            fill_q <= fill_d;
            ev_q   <= ev_d;
        end
    end

    assign above = (sum_q >= bus.threshold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            hold_q   <= '0;
            active_q <= 1'b0;
            onset_q  <= 1'b0;
            offset_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            active_q <= active_d;
            onset_q  <= onset_d;
            offset_q <= offset_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (bus.flush) begin
            state_d = FILL;
            hold_d  = '0;
        end else if (ev_q) begin
            unique case (state_q)
                FILL, BELOW: begin
                    state_d = above ? ABOVE : BELOW;
                    hold_d  = '0;
                end
                ABOVE: begin
                    if (!above) begin
                        if (HOLD_SAMPLES <= 1) begin
                            state_d = BELOW;
                        end else begin
                            state_d = HOLD;
                            hold_d  = HW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (above) begin
                        state_d = ABOVE;
                        hold_d  = '0;
                    end else if (hold_q >= HOLD_LAST) begin
                        state_d = BELOW;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // A flush drops active silently, so no offset edge is reported.
    always_comb begin
        active_d = (state_d == ABOVE) || (state_d == HOLD);
        onset_d  = active_d & ~active_q;
        offset_d = ~active_d & active_q & ~bus.flush;
    end

    assign bus.energy_valid = ev_q;
    assign bus.energy       = sum_q;
    assign bus.active       = active_q;
    assign bus.onset        = onset_q;
    assign bus.offset       = offset_q;
endmodule
